// File: rtl/adc_to_opfb_pkg.sv
// Shared types and constants for the ADC-to-OPFB deadlock reporter slice.
package adc_to_opfb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_REPORTED = 2'd2
  } state_t;

  localparam int DEFAULT_THRESH = 1024;
  localparam int EVT_W          = 8;
  localparam int PERSIST_W      = 16;
  localparam int CYC_W          = 32;

endpackage

// File: rtl/adc_to_opfb_deadlock_reporter_if.sv
// Monitor inputs and latched report outputs of the deadlock reporter.
interface adc_to_opfb_deadlock_reporter_if
  import adc_to_opfb_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2
);
  logic [NUM_MON-1:0] mon_block;
  logic               ap_idle;
  logic               clear_req;
  logic               deadlock;
  logic [NUM_MON-1:0] blk_mask;
  logic [IDX_W-1:0]   first_idx;
  logic [EVT_W-1:0]   event_count;
  logic [CYC_W-1:0]   timestamp;

  modport master (
    output mon_block, ap_idle, clear_req,
    input  deadlock, blk_mask, first_idx, event_count, timestamp
  );

  modport slave (
    input  mon_block, ap_idle, clear_req,
    output deadlock, blk_mask, first_idx, event_count, timestamp
  );
endinterface

// File: rtl/adc_to_opfb_prio_enc.sv
// Index of the lowest set bit; returns 0 when no bit is set.
module adc_to_opfb_prio_enc #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = $clog2(NUM_MON)
) (
  input  logic [NUM_MON-1:0] vec,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/adc_to_opfb_deadlock_reporter.sv
// Aggregates per-instance block flags and latches a sticky deadlock report.
//   state       | meaning
//   ST_IDLE     | no blocked window open
//   ST_CHECK    | counting consecutive qualifying cycles
//   ST_REPORTED | report latched, waiting for clear_req
module adc_to_opfb_deadlock_reporter
  import adc_to_opfb_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int THRESH  = DEFAULT_THRESH,
  parameter int IDX_W   = $clog2(NUM_MON)
) (
  input  logic                            clock,
  input  logic                            reset,
  adc_to_opfb_deadlock_reporter_if.slave  bus
);

  localparam logic [PERSIST_W-1:0] TERM = PERSIST_W'(THRESH - 1);

  state_t               state_q, state_d;
  logic [PERSIST_W-1:0] cnt_q, cnt_d;
  logic [NUM_MON-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 dl_q, dl_d;
  logic [CYC_W-1:0]     ts_q, ts_d;
  logic [EVT_W-1:0]     evt_q, evt_d;
  logic [CYC_W-1:0]     cyc_q;
  logic [IDX_W-1:0]     low_idx;
  logic                 qual;

  adc_to_opfb_prio_enc #(.NUM_MON(NUM_MON), .IDX_W(IDX_W)) u_prio_enc (
    .vec (bus.mon_block),
    .idx (low_idx)
  );

  assign qual = (|bus.mon_block) && !bus.ap_idle;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    dl_d    = dl_q;
    ts_d    = ts_q;
    evt_d   = evt_q;
    case (state_q)
      ST_IDLE: begin
        if (qual) begin
          state_d = ST_CHECK;
          cnt_d   = PERSIST_W'(1);
          mask_d  = bus.mon_block;
          idx_d   = low_idx;
        end
      end
      ST_CHECK: begin
        if (!qual) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          mask_d  = '0;
        end else begin
          mask_d = mask_q | bus.mon_block;
          // The THRESHth qualifying cycle reports; the counter stays at THRESH-1.
          if (cnt_q == TERM) begin
            state_d = ST_REPORTED;
            dl_d    = 1'b1;
            ts_d    = cyc_q;
            evt_d   = (evt_q == '1) ? evt_q : evt_q + EVT_W'(1);
          end else begin
            cnt_d = cnt_q + PERSIST_W'(1);
          end
        end
      end
      ST_REPORTED: begin
        if (bus.clear_req) begin
          state_d = ST_IDLE;
          dl_d    = 1'b0;
          mask_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      mask_q <= '0;
      idx_q  <= '0;
      dl_q   <= 1'b0;
      ts_q   <= '0;
      evt_q  <= '0;
      cyc_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      idx_q  <= idx_d;
      dl_q   <= dl_d;
      ts_q   <= ts_d;
      evt_q  <= evt_d;
      cyc_q  <= cyc_q + CYC_W'(1);
    end
  end

  assign bus.deadlock    = dl_q;
  assign bus.blk_mask    = mask_q;
  assign bus.first_idx   = idx_q;
  assign bus.event_count = evt_q;
  assign bus.timestamp   = ts_q;

endmodule

// File: tb/tb_adc_to_opfb_deadlock_reporter.sv
// Directed bench: default-size reporter plus a THRESH=2 instance for saturation.
module tb_adc_to_opfb_deadlock_reporter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   ts1 = 0;

  always #5 clock = ~clock;

  adc_to_opfb_deadlock_reporter_if #(.NUM_MON(4), .IDX_W(2)) bus ();
  adc_to_opfb_deadlock_reporter_if #(.NUM_MON(2), .IDX_W(1)) bus_s ();

  adc_to_opfb_deadlock_reporter #(.NUM_MON(4), .THRESH(1024), .IDX_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  adc_to_opfb_deadlock_reporter #(.NUM_MON(2), .THRESH(2), .IDX_W(1)) dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (bus_s)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_main();
    bus.clear_req = 1'b1;
    tick(1);
    bus.clear_req = 1'b0;
    bus.mon_block = 4'b0000;
    tick(1);
  endtask

  initial begin
    bus.mon_block   = 4'b0000;
    bus.ap_idle     = 1'b0;
    bus.clear_req   = 1'b0;
    bus_s.mon_block = 2'b00;
    bus_s.ap_idle   = 1'b0;
    bus_s.clear_req = 1'b0;
    tick(3);
    chk("rst_deadlock", 32'(bus.deadlock), 32'd0);
    chk("rst_mask", 32'(bus.blk_mask), 32'd0);
    chk("rst_idx", 32'(bus.first_idx), 32'd0);
    chk("rst_evt", 32'(bus.event_count), 32'd0);
    chk("rst_ts", bus.timestamp, 32'd0);
    reset = 1'b0;
    cyc = 0;

    // basic report on monitor 2
    bus.mon_block = 4'b0100;
    tick(1023);
    chk("t1_pre", 32'(bus.deadlock), 32'd0);
    tick(1);
    chk("t1_dl", 32'(bus.deadlock), 32'd1);
    chk("t1_idx", 32'(bus.first_idx), 32'd2);
    chk("t1_mask", 32'(bus.blk_mask), 32'h4);
    chk("t1_evt", 32'(bus.event_count), 32'd1);
    chk("t1_ts", bus.timestamp, 32'd1023);
    ts1 = 1023;

    // report holds through input changes
    bus.mon_block = 4'b1001;
    bus.ap_idle   = 1'b1;
    tick(20);
    chk("hold_dl", 32'(bus.deadlock), 32'd1);
    chk("hold_mask", 32'(bus.blk_mask), 32'h4);
    chk("hold_idx", 32'(bus.first_idx), 32'd2);
    chk("hold_ts", bus.timestamp, 32'(ts1));

    // clear while still blocked, then re-report
    bus.mon_block = 4'b0001;
    bus.ap_idle   = 1'b0;
    bus.clear_req = 1'b1;
    tick(1);
    bus.clear_req = 1'b0;
    chk("clr_dl", 32'(bus.deadlock), 32'd0);
    chk("clr_mask", 32'(bus.blk_mask), 32'd0);
    chk("clr_evt", 32'(bus.event_count), 32'd1);
    chk("clr_ts", bus.timestamp, 32'(ts1));
    tick(1023);
    chk("t2_pre", 32'(bus.deadlock), 32'd0);
    tick(1);
    chk("t2_dl", 32'(bus.deadlock), 32'd1);
    chk("t2_evt", 32'(bus.event_count), 32'd2);
    chk("t2_mask", 32'(bus.blk_mask), 32'h1);
    chk("t2_ts", bus.timestamp, 32'(cyc - 1));
    clear_main();

    // one-cycle gap restarts the window; clear_req in CHECK ignored
    bus.mon_block = 4'b0001;
    tick(1023);
    bus.mon_block = 4'b0000;
    tick(1);
    chk("gap_dl", 32'(bus.deadlock), 32'd0);
    bus.mon_block = 4'b0001;
    tick(500);
    bus.clear_req = 1'b1;
    tick(1);
    bus.clear_req = 1'b0;
    tick(522);
    chk("t3_pre", 32'(bus.deadlock), 32'd0);
    tick(1);
    chk("t3_dl", 32'(bus.deadlock), 32'd1);
    chk("t3_evt", 32'(bus.event_count), 32'd3);
    clear_main();

    // ap_idle masks blocking entirely
    bus.mon_block = 4'b1010;
    bus.ap_idle   = 1'b1;
    tick(5000);
    chk("idle_dl", 32'(bus.deadlock), 32'd0);
    chk("idle_mask", 32'(bus.blk_mask), 32'd0);
    bus.ap_idle = 1'b0;
    tick(1023);
    chk("t4_pre", 32'(bus.deadlock), 32'd0);
    tick(1);
    chk("t4_dl", 32'(bus.deadlock), 32'd1);
    chk("t4_idx", 32'(bus.first_idx), 32'd1);
    chk("t4_mask", 32'(bus.blk_mask), 32'hA);
    chk("t4_evt", 32'(bus.event_count), 32'd4);
    clear_main();

    // first_idx fixed at window start, mask accumulates
    bus.mon_block = 4'b1000;
    tick(10);
    bus.mon_block = 4'b0010;
    tick(1013);
    chk("t5_pre", 32'(bus.deadlock), 32'd0);
    tick(1);
    chk("t5_dl", 32'(bus.deadlock), 32'd1);
    chk("t5_idx", 32'(bus.first_idx), 32'd3);
    chk("t5_mask", 32'(bus.blk_mask), 32'hA);
    chk("t5_evt", 32'(bus.event_count), 32'd5);
    clear_main();

    // reset mid-window
    bus.mon_block = 4'b0100;
    tick(500);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    cyc = 0;
    chk("mr_dl", 32'(bus.deadlock), 32'd0);
    chk("mr_mask", 32'(bus.blk_mask), 32'd0);
    chk("mr_idx", 32'(bus.first_idx), 32'd0);
    chk("mr_evt", 32'(bus.event_count), 32'd0);
    chk("mr_ts", bus.timestamp, 32'd0);
    tick(1023);
    chk("t6_pre", 32'(bus.deadlock), 32'd0);
    tick(1);
    chk("t6_dl", 32'(bus.deadlock), 32'd1);
    chk("t6_evt", 32'(bus.event_count), 32'd1);
    chk("t6_ts", bus.timestamp, 32'd1023);
    bus.mon_block = 4'b0000;

    // THRESH=2 instance: minimum threshold, clear with qualifying, saturation
    bus_s.mon_block = 2'b10;
    tick(1);
    chk("s_pre", 32'(bus_s.deadlock), 32'd0);
    tick(1);
    chk("s_dl", 32'(bus_s.deadlock), 32'd1);
    chk("s_idx", 32'(bus_s.first_idx), 32'd1);
    chk("s_evt", 32'(bus_s.event_count), 32'd1);
    bus_s.clear_req = 1'b1;
    tick(1);
    bus_s.clear_req = 1'b0;
    chk("s_clr", 32'(bus_s.deadlock), 32'd0);
    tick(1);
    chk("s_nostart", 32'(bus_s.deadlock), 32'd0);
    tick(1);
    chk("s_re_dl", 32'(bus_s.deadlock), 32'd1);
    chk("s_re_evt", 32'(bus_s.event_count), 32'd2);
    for (int r = 0; r < 300; r++) begin
      bus_s.clear_req = 1'b1;
      tick(1);
      bus_s.clear_req = 1'b0;
      tick(2);
    end
    chk("s_sat", 32'(bus_s.event_count), 32'd255);
    chk("s_sat_dl", 32'(bus_s.deadlock), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_to_opfb_deadlock_reporter.md
ADC_TO_OPFB_DEADLOCK_REPORTER -- requirements
Module: adc_to_opfb_deadlock_reporter

Interface
REQ-001 Parameter NUM_MON, default 4, number of per-instance deadlock monitors aggregated (2..16).
REQ-002 Parameter THRESH, default 1024, number of consecutive blocked cycles before a deadlock is declared (2..65535).
REQ-003 Parameter IDX_W, default 2, index width, equal to clog2(NUM_MON).
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mon_block  input  NUM_MON  per-monitor block outputs; bit i comes from monitor i.
REQ-007 ap_idle  input  1  top-level idle; while high, blocking is not treated as deadlock.
REQ-008 clear_req  input  1  single-cycle pulse that acknowledges and clears a latched report.
REQ-009 deadlock  output  1  sticky deadlock flag.
REQ-010 blk_mask  output  NUM_MON  OR of mon_block over the qualifying window, frozen at report.
REQ-011 first_idx  output  IDX_W  lowest-numbered monitor blocked on the first cycle of the window.
REQ-012 event_count  output  8  number of deadlocks declared since reset, saturating.
REQ-013 timestamp  output  32  free-running cycle count captured at the report.

Function
REQ-014 The block SHALL implement three states: IDLE, CHECK and REPORTED.
REQ-015 A cycle is "qualifying" when (|mon_block) and not ap_idle.
REQ-016 IDLE: on a qualifying cycle -> CHECK; persist counter loaded with 1; blk_mask loaded with mon_block; first_idx loaded with the lowest set bit index.
REQ-017 CHECK, qualifying cycle: counter increments by 1; blk_mask |= mon_block; first_idx held.
REQ-018 CHECK, non-qualifying cycle: -> IDLE; counter cleared to 0; blk_mask cleared to 0.
REQ-019 CHECK, qualifying cycle with counter == THRESH-1: -> REPORTED; deadlock asserted on the next cycle; timestamp latched from the free-running counter; event_count incremented.
REQ-020 Deadlock is therefore declared after exactly THRESH consecutive qualifying cycles, with deadlock high on the cycle following the THRESHth qualifying cycle.
REQ-021 REPORTED: deadlock, blk_mask, first_idx and timestamp SHALL be held regardless of mon_block or ap_idle.
REQ-022 REPORTED with clear_req: -> IDLE; deadlock, blk_mask and counter cleared; event_count and timestamp kept.
REQ-023 clear_req in IDLE or CHECK SHALL be ignored.
REQ-024 clear_req and a qualifying cycle together in REPORTED -> IDLE; a new window starts no earlier than the following cycle.
REQ-025 event_count SHALL saturate at 255 and never wrap.
REQ-026 The free-running cycle counter is 32 bits, increments every cycle, and wraps from 0xFFFFFFFF to 0.
REQ-027 The persist counter is 16 bits and never exceeds THRESH-1.
REQ-028 All outputs SHALL be registered; there is no combinational path from input to output.

Reset
REQ-029 reset forces state IDLE and zeroes deadlock, blk_mask, first_idx, event_count, timestamp, the persist counter and the cycle counter.
REQ-030 reset asserted in CHECK or REPORTED SHALL abandon the window and the report without incrementing event_count.

Structure
REQ-031 The state enum, the default THRESH and the event_count width SHALL be defined in the shared adc_to_opfb package.
REQ-032 The lowest-set-bit encoder SHALL be a sub-module, adc_to_opfb_prio_enc, parameterised on NUM_MON.

Verification
REQ-033 mon_block=4'b0100 held for 1024 cycles, ap_idle=0 -> deadlock=1 on cycle 1025; first_idx=2; blk_mask=4'b0100; event_count=1.
REQ-034 mon_block=4'b0001 for 1023 cycles, then 0 for 1 cycle, then 4'b0001 again -> no deadlock until a further 1024 consecutive cycles.
REQ-035 mon_block=4'b1010 with ap_idle=1 for 5000 cycles -> deadlock stays 0 and state stays IDLE.
REQ-036 Window starts with 4'b1000, then 4'b0010 from cycle 10 -> first_idx=3; blk_mask=4'b1010 at report.
REQ-037 Report latched, then clear_req pulse with mon_block still 4'b0001 -> deadlock=0 the next cycle; re-reported 1024 cycles later; event_count=2.
REQ-038 Reset asserted at cycle 500 of a CHECK window -> all outputs 0; a full 1024 qualifying cycles are needed to report.
